// File: rtl/fft_bitrev_loader_if.sv
// Stream interface of the FFT bit-reverse input loader: a valid/ready
// sample stream in, a valid/ready butterfly operand-pair stream out.
// The loader connects through the slave modport, its environment through
// the master modport.
interface fft_bitrev_loader_if #(
    parameter int N         = 8,
    parameter int WORD_SIZE = 32
) ();
    localparam int TW_IDX_SIZE = $clog2(N);
    localparam int PAIR_W      = TW_IDX_SIZE - 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_SIZE-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_SIZE-1:0]   num1;
    logic [WORD_SIZE-1:0]   num2;
    logic [TW_IDX_SIZE-1:0] twiddle_index;
    logic [PAIR_W-1:0]      pair_idx;
    logic                   out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, num1, num2, twiddle_index, pair_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, num1, num2, twiddle_index, pair_idx, out_last
    );
endinterface

// File: rtl/fft_bitrev_loader.sv
// Ping-pong input staging buffer ahead of the first 2-point butterfly stage.
// Samples arrive in natural time order; each frame of N samples is written
// into one of two banks, then read back as N/2 adjacent operand pairs.
// Build option: define FFT_BITREV_EN to store samples at bit-reversed
// addresses (decimation-in-time stage 1); leave it undefined for natural
// order storage (decimation-in-frequency pipelines).
module fft_bitrev_loader #(
    parameter int N         = 8,
    parameter int WORD_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    fft_bitrev_loader_if.slave  bus
);
    localparam int TW_IDX_SIZE = $clog2(N);
    localparam int PAIR_W      = TW_IDX_SIZE - 1;
    localparam logic [TW_IDX_SIZE-1:0] LAST_WR   = TW_IDX_SIZE'(N - 1);
    localparam logic [PAIR_W-1:0]      LAST_PAIR = PAIR_W'(N / 2 - 1);

    logic [WORD_SIZE-1:0]   bank_mem [2][N];
    logic [1:0]             full;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [TW_IDX_SIZE-1:0] wr_cnt;
    logic [PAIR_W-1:0]      rd_pair;

    logic                   accept;
    logic                   consume;
    logic [TW_IDX_SIZE-1:0] wr_addr;
    logic [TW_IDX_SIZE-1:0] rd_addr_even;
    logic [TW_IDX_SIZE-1:0] rd_addr_odd;

    // Storage address for the i-th sample of a frame.
    function automatic logic [TW_IDX_SIZE-1:0] addr_of(input logic [TW_IDX_SIZE-1:0] i);
`ifdef FFT_BITREV_EN
        logic [TW_IDX_SIZE-1:0] r;
        for (int b = 0; b < TW_IDX_SIZE; b++) begin
            r[b] = i[TW_IDX_SIZE-1-b];
        end
        return r;
`else
        return i;
`endif
    endfunction

    // Handshakes depend only on registered flags, so there is no
    // combinational path from out_ready to in_ready.
    assign accept       = bus.in_valid && !full[wr_bank];
    assign consume      = full[rd_bank] && bus.out_ready;
    assign wr_addr      = addr_of(wr_cnt);
    assign rd_addr_even = {rd_pair, 1'b0};
    assign rd_addr_odd  = {rd_pair, 1'b1};

    assign bus.in_ready      = !full[wr_bank];
    assign bus.out_valid     = full[rd_bank];
    assign bus.num1          = full[rd_bank] ? bank_mem[rd_bank][rd_addr_even] : '0;
    assign bus.num2          = full[rd_bank] ? bank_mem[rd_bank][rd_addr_odd]  : '0;
    assign bus.pair_idx      = rd_pair;
    assign bus.out_last      = full[rd_bank] && (rd_pair == LAST_PAIR);
    assign bus.twiddle_index = '0;

    // Sample write into the bank currently being filled.
    // NOTE: bank storage is deliberately not reset; its contents are only
    // ever observed through a set full flag, and the flags are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[wr_bank][wr_addr] <= bus.in_data;
        end
    end

    // Fill/drain bookkeeping: write counter, read pair and per-bank flags.
    // NOTE: non-blocking assignments let a fill completing on one bank and a
    // drain completing on the other both land on the same edge, each
    // touching only its own bit of full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_pair <= '0;
        end else begin
            if (accept) begin
                if (wr_cnt == LAST_WR) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_cnt        <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (consume) begin
                if (rd_pair == LAST_PAIR) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_pair       <= '0;
                end else begin
                    rd_pair <= rd_pair + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Self-checking bench for fft_bitrev_loader (N=8, 32-bit words).
// A frame-level reference model (queue of accepted samples, queue of
// expected operand pairs, count of complete frames held) predicts every
// output each cycle. Honours FFT_BITREV_EN the same way the design does.
module tb_fft_bitrev_loader;
    localparam int N    = 8;
    localparam int W    = 32;
    localparam int LOGN = 3;

    typedef struct packed {
        logic         in_ready;
        logic         out_valid;
        logic [W-1:0] num1;
        logic [W-1:0] num2;
        logic [1:0]   pair_idx;
        logic         out_last;
        logic [2:0]   tw;
    } snap_t;

    typedef struct packed {
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        logic [1:0]   idx;
        logic         last;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_bitrev_loader_if #(.N(N), .WORD_SIZE(W)) bus ();

    fft_bitrev_loader #(.N(N), .WORD_SIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    snap_t        obs;
    snap_t        exp_s;
    logic [W-1:0] in_q [$];
    pair_t        pair_q [$];
    int           stored = 0;

    // Where sample i of a frame lives in the bank.
    function automatic int addr_of(input int i);
        int r;
        int v;
        r = 0;
        v = i;
`ifdef FFT_BITREV_EN
        for (int k = 0; k < LOGN; k++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
`else
        r = v;
`endif
        return r;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("in_ready=%b out_valid=%b num1=%0d num2=%0d pair_idx=%0d out_last=%b tw=%0d",
                         s.in_ready, s.out_valid, s.num1, s.num2, s.pair_idx, s.out_last, s.tw);
    endfunction

    // One clock cycle: drive inputs at the falling edge, record what the DUT
    // shows and what the model predicts, then advance the model by the
    // handshakes the model says happen at the next rising edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
        logic [W-1:0] frame [N];
        logic acc;
        logic con;
        pair_t p;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        obs.in_ready  = bus.in_ready;
        obs.out_valid = bus.out_valid;
        obs.num1      = bus.num1;
        obs.num2      = bus.num2;
        obs.pair_idx  = bus.pair_idx;
        obs.out_last  = bus.out_last;
        obs.tw        = bus.twiddle_index;
        exp_s           = '0;
        exp_s.in_ready  = (stored < 2);
        exp_s.out_valid = (stored > 0);
        if (stored > 0) begin
            exp_s.num1     = pair_q[0].n1;
            exp_s.num2     = pair_q[0].n2;
            exp_s.pair_idx = pair_q[0].idx;
            exp_s.out_last = pair_q[0].last;
        end
        acc = v && (stored < 2) && !r;
        con = rdy && (stored > 0) && !r;
        if (r) begin
            in_q.delete();
            pair_q.delete();
            stored = 0;
        end else begin
            if (con) begin
                p = pair_q.pop_front();
                if (p.last) stored--;
            end
            if (acc) begin
                in_q.push_back(d);
                if (in_q.size() == N) begin
                    for (int i = 0; i < N; i++) frame[addr_of(i)] = in_q[i];
                    for (int k = 0; k < N / 2; k++)
                        pair_q.push_back('{frame[2*k], frame[2*k+1], 2'(k), (k == N / 2 - 1)});
                    in_q.delete();
                    stored++;
                end
            end
        end
    endtask

    task automatic test_reset();
        snap_t rst_s;
        rst_s = '0;
        rst_s.in_ready = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (obs !== rst_s) $display("FAIL reset_state: got %s required %s", fmt(obs), fmt(rst_s));
        else n_pass++;
        n_checks++;
        if (obs !== exp_s) $display("FAIL reset_model: got %s required %s", fmt(obs), fmt(exp_s));
        else n_pass++;
    endtask

    task automatic test_frame();
        logic [W-1:0] t1 [4];
        logic [W-1:0] t2 [4];
`ifdef FFT_BITREV_EN
        t1 = '{0, 2, 1, 3};
        t2 = '{4, 6, 5, 7};
`else
        t1 = '{0, 2, 4, 6};
        t2 = '{1, 3, 5, 7};
`endif
        step(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, i < 8, W'(i), 1);
            n_checks++;
            if (obs !== exp_s) $display("FAIL frame_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
            n_checks++;
            if (obs.out_valid !== (i >= 8 && i < 12))
                $display("FAIL frame_latency step %0d: got out_valid=%b required %b", i, obs.out_valid, (i >= 8 && i < 12));
            else n_pass++;
            if (i >= 8 && i < 12) begin
                n_checks++;
                if ({obs.num1, obs.num2, obs.pair_idx, obs.out_last} !== {t1[i-8], t2[i-8], 2'(i - 8), (i == 11)})
                    $display("FAIL frame_pair %0d: got (%0d,%0d) idx=%0d last=%b required (%0d,%0d) idx=%0d last=%b",
                             i - 8, obs.num1, obs.num2, obs.pair_idx, obs.out_last, t1[i-8], t2[i-8], i - 8, (i == 11));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            step(0, i < 17, W'(100 + i), i >= 17);
            n_checks++;
            if (obs !== exp_s) $display("FAIL backpressure_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
            if (i == 16 || i == 20 || i == 21) begin
                n_checks++;
                if (obs.in_ready !== (i == 21))
                    $display("FAIL backpressure_in_ready step %0d: got %b required %b", i, obs.in_ready, (i == 21));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int n_cons;
        n_cons = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 28; i++) begin
            logic rdy;
            rdy = (i >= 8) && (i % 2 == 1);
            step(0, i < 8, W'(300 + 7 * i), rdy);
            n_checks++;
            if (obs !== exp_s) $display("FAIL stall_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
            if (obs.out_valid === 1'b1) begin
                n_checks++;
                if (obs.pair_idx !== 2'(n_cons % 4))
                    $display("FAIL stall_pair_seq step %0d: got pair_idx=%0d required %0d", i, obs.pair_idx, n_cons % 4);
                else n_pass++;
                if (rdy) n_cons++;
            end
        end
        n_checks++;
        if (n_cons !== 4) $display("FAIL stall_pair_count: got %0d required 4", n_cons);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] t1 [4];
        logic [W-1:0] t2 [4];
`ifdef FFT_BITREV_EN
        t1 = '{16, 18, 17, 19};
        t2 = '{20, 22, 21, 23};
`else
        t1 = '{16, 18, 20, 22};
        t2 = '{17, 19, 21, 23};
`endif
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            step(0, i < 24, W'(i), 1);
            n_checks++;
            if (obs !== exp_s) $display("FAIL stream_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
            if (i < 24) begin
                n_checks++;
                if (obs.in_ready !== 1'b1) $display("FAIL stream_in_ready step %0d: got %b required 1", i, obs.in_ready);
                else n_pass++;
            end
            if (i >= 24 && i < 28) begin
                n_checks++;
                if ({obs.out_valid, obs.num1, obs.num2} !== {1'b1, t1[i-24], t2[i-24]})
                    $display("FAIL stream_frame2_pair %0d: got v=%b (%0d,%0d) required v=1 (%0d,%0d)",
                             i - 24, obs.out_valid, obs.num1, obs.num2, t1[i-24], t2[i-24]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, W'(500 + i), 1);
        step(1, 1, 505, 1);
        step(0, 0, 0, 1);
        n_checks++;
        if ({obs.out_valid, obs.in_ready} !== 2'b01)
            $display("FAIL reset_mid_fill: got out_valid=%b in_ready=%b required 0 1", obs.out_valid, obs.in_ready);
        else n_pass++;
        for (int i = 0; i < 11; i++) begin
            step(i == 10, i < 8, W'(600 + i), 1);
            n_checks++;
            if (obs !== exp_s) $display("FAIL reset_mid_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
        end
        n_checks++;
        if ({obs.out_valid, obs.pair_idx} !== {1'b1, 2'd2})
            $display("FAIL reset_mid_pair2: got out_valid=%b pair_idx=%0d required 1 2", obs.out_valid, obs.pair_idx);
        else n_pass++;
        step(0, 0, 0, 1);
        n_checks++;
        if ({obs.out_valid, obs.in_ready} !== 2'b01)
            $display("FAIL reset_mid_drain: got out_valid=%b in_ready=%b required 0 1", obs.out_valid, obs.in_ready);
        else n_pass++;
        for (int i = 0; i < 14; i++) begin
            step(0, i < 8, W'(700 + i), 1);
            n_checks++;
            if (obs !== exp_s) $display("FAIL reset_mid_fresh step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
            if (obs.out_valid === 1'b1) begin
                n_checks++;
                if (obs.num1 < 700 || obs.num1 > 707 || obs.num2 < 700 || obs.num2 > 707)
                    $display("FAIL reset_mid_stale step %0d: got (%0d,%0d) required values in 700..707", i, obs.num1, obs.num2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 150) == 0, ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
            n_checks++;
            if (obs !== exp_s) $display("FAIL random_model step %0d: got %s required %s", i, fmt(obs), fmt(exp_s));
            else n_pass++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_frame();
        test_backpressure();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
